// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit:
//                sequencing states, RV32I funct3 width codes and the
//                address of the one memory word that has no storage.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // The data memory is 255 words deep; word index 0xFF has no storage.
    localparam logic [7:0] UNBACKED_WORD = 8'hFF;

    // True when funct3 is not a width code valid for this direction.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic r;
        if (we) begin
            r = (f3 > F3_W);
        end else begin
            r = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                  (f3 == F3_BU) || (f3 == F3_HU));
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic. Request path turns funct3, the
//                byte offset and right-aligned store data into a byte mask,
//                lane-replicated write data and a misalignment flag. Load
//                path selects the addressed byte/halfword from a memory word
//                and sign- or zero-extends it.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_funct3_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_mask_o,
    output logic [31:0] req_data_o,
    output logic        req_misalign_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_result_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Mask, replicated data and alignment check from the access width (funct3[1:0]).
    always_comb begin
        req_mask_o     = 4'b0000;
        req_data_o     = req_wdata_i;
        req_misalign_o = 1'b0;
        case (req_funct3_i[1:0])
            2'd0: begin
                req_mask_o = 4'b0001 << req_off_i;
                req_data_o = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                req_mask_o     = req_off_i[1] ? 4'b1100 : 4'b0011;
                req_data_o     = {2{req_wdata_i[15:0]}};
                req_misalign_o = req_off_i[0];
            end
            2'd2: begin
                req_mask_o     = 4'b1111;
                req_misalign_o = (req_off_i != 2'b00);
            end
            default: begin
                req_mask_o     = 4'b0000;
                req_misalign_o = 1'b0;
            end
        endcase
    end

    // Lane selection and extension of the returned memory word.
    always_comb begin
        w_byte      = ld_word_i[{ld_off_i, 3'b000} +: 8];
        w_half      = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_result_o = 32'h0;
        case (ld_funct3_i)
            F3_B:    ld_result_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   ld_result_o = {24'h0, w_byte};
            F3_H:    ld_result_o = {{16{w_half[15]}}, w_half};
            F3_HU:   ld_result_o = {16'h0, w_half};
            F3_W:    ld_result_o = ld_word_i;
            default: ld_result_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Sequences one RV32I load or store at a time into a
//                byte-masked data memory with a one-cycle registered read.
//                Illegal, misaligned or unbacked accesses complete with an
//                error and never reach the memory. All outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_funct3_i,
    input  logic [31:0]       lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_ready_o,
    output logic              lsu_done_o,
    output logic              lsu_err_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              mem_request_o,
    output logic              mem_we_re_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [31:0]       mem_data_in_o,
    output logic [3:0]        mem_mask_o,
    input  logic [31:0]       mem_data_out_i
);

    lsu_state_e        state_q, state_d;

    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [3:0]        mem_mask_q, mem_mask_d;

    logic [3:0]        w_st_mask;
    logic [31:0]       w_st_data;
    logic              w_misalign;
    logic [31:0]       w_ld_result;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_reject;

    // Upper address bits are deliberately dropped: the space wraps every 1 KiB.
    logic              w_unused_addr;
    assign w_unused_addr = ^lsu_addr_i[31:ADDR_W+2];

    assign w_word_idx = lsu_addr_i[ADDR_W+1:2];
    assign w_reject   = f3_illegal(lsu_we_i, lsu_funct3_i) || w_misalign ||
                        (w_word_idx == ADDR_W'(UNBACKED_WORD));

    // Request lanes come from the live inputs (used only on accept); load
    // extraction uses the captured funct3/offset against the returned word.
    lsu_align u_align (
        .req_funct3_i   (lsu_funct3_i),
        .req_off_i      (lsu_addr_i[1:0]),
        .req_wdata_i    (lsu_wdata_i),
        .req_mask_o     (w_st_mask),
        .req_data_o     (w_st_data),
        .req_misalign_o (w_misalign),
        .ld_funct3_i    (f3_q),
        .ld_off_i       (off_q),
        .ld_word_i      (mem_data_out_i),
        .ld_result_o    (w_ld_result)
    );

    // Next-state and next-output decode; every output is a registered copy.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        off_d      = off_q;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_mask_d = mem_mask_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_valid_i) begin
                    we_d    = lsu_we_i;
                    f3_d    = lsu_funct3_i;
                    off_d   = lsu_addr_i[1:0];
                    rdata_d = 32'h0;
                    if (w_reject) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        mem_we_d   = lsu_we_i;
                        mem_addr_d = w_word_idx;
                        if (lsu_we_i) begin
                            mem_data_d = w_st_data;
                            mem_mask_d = w_st_mask;
                        end
                    end
                end
            end
            S_REQ:   state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT: begin
                rdata_d = w_ld_result;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_RESP);
        req_d   = (state_d == S_REQ);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured operation and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            req_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= 32'h0;
            mem_mask_q <= 4'h0;
        end else begin
            we_q       <= we_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            req_q      <= req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_mask_q <= mem_mask_d;
        end
    end

    assign lsu_ready_o   = ready_q;
    assign lsu_done_o    = done_q;
    assign lsu_err_o     = err_q;
    assign lsu_rdata_o   = rdata_q;
    assign mem_request_o = req_q;
    assign mem_we_re_o   = mem_we_q;
    assign mem_address_o = mem_addr_q;
    assign mem_data_in_o = mem_data_q;
    assign mem_mask_o    = mem_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Scoreboard bench for load_store_unit with a behavioural
//                data memory and a byte-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = 3'd0;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wdata = 32'h0;
    logic        lsu_ready, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_request, mem_we_re;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_mask;
    logic [31:0] mem_data_out;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid_i    (lsu_valid),
        .lsu_we_i       (lsu_we),
        .lsu_funct3_i   (lsu_funct3),
        .lsu_addr_i     (lsu_addr),
        .lsu_wdata_i    (lsu_wdata),
        .lsu_ready_o    (lsu_ready),
        .lsu_done_o     (lsu_done),
        .lsu_err_o      (lsu_err),
        .lsu_rdata_o    (lsu_rdata),
        .mem_request_o  (mem_request),
        .mem_we_re_o    (mem_we_re),
        .mem_address_o  (mem_address),
        .mem_data_in_o  (mem_data_in),
        .mem_mask_o     (mem_mask),
        .mem_data_out_i (mem_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural data memory (environment) ----------------
    logic [31:0] mem [0:255];
    logic [31:0] mem_rd = 32'h0;
    assign mem_data_out = mem_rd;

    always @(posedge clk) begin
        if (mem_request && mem_address != 8'hFF) begin
            if (mem_we_re) begin
                for (int j = 0; j < 4; j++)
                    if (mem_mask[j]) mem[mem_address][8*j +: 8] <= mem_data_in[8*j +: 8];
            end else begin
                mem_rd <= mem[mem_address];
            end
        end
    end

    // ---------------- reference model: 1 KiB byte array ----------------
    logic [7:0] ref_mem [0:1023];

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;
    exp_t q[$];

    int          checks = 0;
    int          errors = 0;
    int          next_free = 0;
    int          exp_req_cyc = -1;
    bit          exp_we;
    logic [7:0]  exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = 1 << f3[1:0];
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if ((a % size) != 0) return 1'b1;
        if (((a >> 2) & 255) == 255) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int size;
        int base;
        logic [31:0] v;
        size = 1 << f3[1:0];
        base = int'(a & 32'd1023);
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    // Record one accepted operation: expected request, readiness, response.
    task automatic accept(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit commit);
        bit   e;
        int   lat;
        int   size;
        int   base;
        exp_t x;
        e    = ref_err(we, f3, a);
        lat  = e ? 1 : (we ? 2 : 3);
        size = 1 << f3[1:0];
        base = int'(a & 32'd1023);
        next_free = cyc + lat + 1;
        if (!e) begin
            exp_req_cyc = cyc + 1;
            exp_we      = we;
            exp_addr    = 8'((a >> 2) & 32'd255);
            exp_mask    = 4'h0;
            for (int i = 0; i < size; i++) exp_mask[(base % 4) + i] = 1'b1;
            for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = wd[8*(j % size) +: 8];
        end
        if (commit) begin
            x.err      = e;
            x.rdata    = (e || we) ? 32'h0 : ref_load(f3, a);
            x.done_cyc = cyc + lat;
            if (!e && we)
                for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
            q.push_back(x);
        end
    endtask

    // Drive one cycle's inputs (caller is at a falling edge).
    task automatic drive(input bit v, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit commit);
        lsu_valid  = v;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = a;
        lsu_wdata  = wd;
        if (v && cyc >= next_free) accept(we, f3, a, wd, commit);
    endtask

    task automatic op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit commit);
        @(negedge clk);
        for (int i = 0; i < 10 && cyc < next_free; i++) begin
            lsu_valid = 1'b0;
            @(negedge clk);
        end
        drive(1'b1, we, f3, a, wd, commit);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, lsu_ready, 1);
        chk({tag, "_done"}, lsu_done, 0);
        chk({tag, "_err"}, lsu_err, 0);
        chk({tag, "_rdata"}, lsu_rdata, 0);
        chk({tag, "_mem_request"}, mem_request, 0);
        chk({tag, "_mem_we_re"}, mem_we_re, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_data_in"}, mem_data_in, 0);
        chk({tag, "_mem_mask"}, mem_mask, 0);
    endtask

    // Abort an access with reset: a store during REQ, a load during WAIT.
    task automatic abort_test(input bit is_load, input logic [31:0] a);
        op(!is_load, 3'd2, a, 32'hC0FF_EE00 ^ $urandom, 1'b0);
        @(negedge clk);
        lsu_valid = 1'b0;
        if (is_load) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs(is_load ? "abort_ld" : "abort_st");
        exp_req_cyc = -1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        next_free = cyc;
        op(1'b0, 3'd2, a, 32'h0, 1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (!rst) begin
            chk("ready", lsu_ready, (cyc >= next_free) ? 1 : 0);
            chk("mem_request", mem_request, (cyc == exp_req_cyc) ? 1 : 0);
            if (cyc == exp_req_cyc) begin
                chk("mem_we_re", mem_we_re, exp_we);
                chk("mem_address", mem_address, exp_addr);
                if (exp_we) begin
                    chk("mem_mask", mem_mask, exp_mask);
                    chk("mem_data_in", mem_data_in, exp_wdata);
                end
            end
            if (q.size() > 0 && q[0].done_cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_done: expected in cycle %0d, none by cycle %0d", q[0].done_cyc, cyc);
                void'(q.pop_front());
            end
            if (lsu_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d: err %b rdata %h, none required", cyc, lsu_err, lsu_rdata);
                end else begin
                    x = q.pop_front();
                    chk("done_cycle", cyc, x.done_cyc);
                    chk("err", lsu_err, x.err);
                    chk("rdata", lsu_rdata, x.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] tmp;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int w = 0; w < 256; w++) begin
            tmp = $urandom;
            mem[w] = tmp;
            for (int j = 0; j < 4; j++) ref_mem[4*w + j] = tmp[8*j +: 8];
        end

        #1 rst = 1'b1;
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed sequence
        op(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);  // SW
        op(1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b1);          // LW
        op(1'b1, 3'd0, 32'h0000_0013, 32'h0000_00A5, 1'b1);  // SB
        op(1'b0, 3'd0, 32'h0000_0013, 32'h0, 1'b1);          // LB
        op(1'b0, 3'd4, 32'h0000_0013, 32'h0, 1'b1);          // LBU
        op(1'b1, 3'd1, 32'h0000_0022, 32'h0000_8001, 1'b1);  // SH
        op(1'b0, 3'd1, 32'h0000_0022, 32'h0, 1'b1);          // LH
        op(1'b0, 3'd5, 32'h0000_0022, 32'h0, 1'b1);          // LHU
        op(1'b0, 3'd2, 32'h0000_0020, 32'h0, 1'b1);          // LW
        op(1'b0, 3'd2, 32'h0000_0011, 32'h0, 1'b1);          // LW misaligned
        op(1'b0, 3'd1, 32'h0000_0003, 32'h0, 1'b1);          // LH misaligned
        op(1'b0, 3'd3, 32'h0000_0040, 32'h0, 1'b1);          // load funct3 3
        op(1'b1, 3'd2, 32'h0000_03FC, 32'h1234_5678, 1'b1);  // SW to unbacked word
        op(1'b1, 3'd3, 32'h0000_0040, 32'h1111_1111, 1'b1);  // store funct3 3
        op(1'b0, 3'd2, 32'hABC0_0010, 32'h0, 1'b1);          // LW wraps to 0x10

        abort_test(1'b0, 32'h0000_0050);
        abort_test(1'b1, 32'h0000_0060);

        // Randomised phase: valid mostly held high, inputs change every cycle
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            a = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                else if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 3) == 0) a[9:0] = {6'h3F & 6'($urandom), a[3:0]};
            drive($urandom_range(0, 3) != 0, we, f3, a, $urandom, 1'b1);
        end
        @(negedge clk);
        lsu_valid = 1'b0;
        repeat (8) @(negedge clk);

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_responses: %0d left, 0 required", q.size());
        end
        for (int w = 0; w < 255; w++)
            chk("mem_word", mem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
